rom_load_sequencer: RTL
=======================

// Module: rom_load_sequencer
// PURPOSE
//  Programs the ROM chips' wishbone backdoor from a byte stream (valid/ready) and sequences the CPU around it.
//  Holds the CPU halted, writes LEN bytes starting at a 12-bit program address, then pulses CPU reset and releases halt.
//  Decodes program address to chip: chip = addr >> ADDR_BITS; one wishbone strobe per ROM chip, shared addr/data.
// PARAMETERS
//  NUM_ROMS      4    number of ROM chips driven (1..16)
//  ROM_CAPACITY  256  bytes per chip; ADDR_BITS = $clog2(ROM_CAPACITY)
//  HALT_SETTLE   8    cycles between halt assert and first write (>=1; >=8 covers one full bus cycle)
//  RESET_CYCLES  4    width of cpu_reset pulse after loading (>=1)
//  ACK_TIMEOUT   15   max cycles waiting for wb_ack (only with ROM_LOAD_TIMEOUT_EN)
// PORTS
//  clock        in   1         system clock
//  reset        in   1         synchronous, active-high
//  start        in   1         pulse: begin load (ignored unless IDLE)
//  base_addr    in   12        first program address
//  len          in   12        byte count; 0 = no writes, still halts and resets CPU
//  byte_valid   in   1         stream byte available
//  byte_data    in   8         stream byte
//  byte_ready   out  1         byte consumed this cycle when valid&ready
//  wb_cyc_o     out  1         wishbone cycle
//  wb_stb_o     out  NUM_ROMS  one-hot strobe, bit = target chip
//  wb_we_o      out  1         always 1 when wb_cyc_o
//  wb_addr_o    out  32        {18'b0, offset[ADDR_BITS-1:0], 2'b00}
//  wb_data_o    out  32        {24'b0, byte}
//  wb_ack_i     in   NUM_ROMS  per-chip ack, OR-reduced
//  halt         out  1         CPU/ROM halt
//  cpu_reset    out  1         CPU reset pulse
//  busy         out  1         state != IDLE
//  done         out  1         one-cycle pulse on completion
//  error        out  1         sticky until next start: bad chip index or timeout
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; counters 0. Reset mid-load aborts immediately, halt drops next cycle.
//  States: IDLE -> HALT -> FETCH -> WRITE -> (FETCH | RELEASE) -> IDLE.
//  IDLE: start latches base_addr->ptr, len->remaining, clears error; halt=1 from next cycle.
//  HALT: count HALT_SETTLE cycles, then FETCH (or RELEASE if remaining==0).
//  FETCH: byte_ready=1; on byte_valid capture byte, go WRITE next cycle. byte_ready=0 in all other states.
//  WRITE: wb_cyc_o=1, wb_stb_o[chip]=1 registered, held until any wb_ack_i seen; drop cyc/stb cycle after ack.
//   Then ptr+=1 (12-bit wrap 0xFFF->0x000), remaining-=1; remaining==0 -> RELEASE else FETCH.
//   Min per byte: 3 cycles (fetch, strobe, ack) with a one-cycle-ack ROM.
//  Chip index >= NUM_ROMS: no strobe, byte consumed and dropped, error=1, load continues.
//  RELEASE: cpu_reset=1 for RESET_CYCLES with halt still 1; then halt=0, cpu_reset=0, done=1 for 1 cycle, IDLE.
//  Chip boundary crossing (e.g. 0x0FF->0x100) switches strobe bit with no extra cycles.
//  start while busy: ignored. ack outside WRITE: ignored.
//  halt covers whole load so ROM accepts writes on any subcycle.
// CONFIGURATION
//  ROM_LOAD_TIMEOUT_EN defined: WRITE counts cycles; if no ack by ACK_TIMEOUT, drop cyc/stb,
//   set error, skip the byte (advance ptr/remaining) as if acked.
//  Not defined: WRITE waits indefinitely for ack; error set only by bad chip index; ACK_TIMEOUT unused.
// TESTING
//  start base=0x000 len=3 bytes A5,3C,FF, ack 1 cycle after stb -> ROM0 offsets 0..2 written, addr 0x0/0x4/0x8, done once, error=0.
//  base=0x0FE len=4 -> writes ROM0 0xFE,0xFF then ROM1 0x00,0x01; wb_stb_o 0001,0001,0010,0010.
//  len=0 -> halt high HALT_SETTLE+RESET_CYCLES cycles, cpu_reset RESET_CYCLES wide, no wb_cyc_o, done pulse.
//  NUM_ROMS=2, base=0x1FF len=2 -> ROM1 0xFF written; next byte no strobe, error=1, done still pulses.
//  byte_valid gapped 5 cycles each byte, then reset asserted during WRITE -> all outputs 0 next cycle, IDLE.
//  ROM_LOAD_TIMEOUT_EN, ack never driven -> stb drops after 15 cycles, error=1, load completes; without macro busy holds.

Source files
------------

// File: rtl/rom_load_sequencer.sv
// rom_load_sequencer: halts the CPU, streams bytes into the ROM chips over a shared wishbone
// backdoor, then pulses CPU reset. Define ROM_LOAD_TIMEOUT_EN to bound each write by ACK_TIMEOUT.
module rom_load_sequencer #(
    parameter int NUM_ROMS     = 4,
    parameter int ROM_CAPACITY = 256,
    parameter int HALT_SETTLE  = 8,
    parameter int RESET_CYCLES = 4,
    parameter int ACK_TIMEOUT  = 15
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [11:0]         base_addr,
    input  logic [11:0]         len,
    input  logic                byte_valid,
    input  logic [7:0]          byte_data,
    output logic                byte_ready,
    output logic                wb_cyc_o,
    output logic [NUM_ROMS-1:0] wb_stb_o,
    output logic                wb_we_o,
    output logic [31:0]         wb_addr_o,
    output logic [31:0]         wb_data_o,
    input  logic [NUM_ROMS-1:0] wb_ack_i,
    output logic                halt,
    output logic                cpu_reset,
    output logic                busy,
    output logic                done,
    output logic                error
);
    localparam int ADDR_BITS = $clog2(ROM_CAPACITY);
    localparam logic [11:0] OFFSET_MASK = 12'((1 << ADDR_BITS) - 1);
    localparam logic [11:0] ROM_COUNT   = 12'(NUM_ROMS);
    localparam logic [15:0] HALT_LAST   = 16'(HALT_SETTLE - 1);
    localparam logic [15:0] RESET_LAST  = 16'(RESET_CYCLES - 1);
    // The phase counter only needs to reach the longest timed phase; it saturates there.
    localparam int CNT_MAX_A = (HALT_SETTLE > RESET_CYCLES) ? HALT_SETTLE : RESET_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > ACK_TIMEOUT) ? CNT_MAX_A : ACK_TIMEOUT;
    localparam logic [15:0] CNT_TOP = 16'(CNT_MAX);
`ifdef ROM_LOAD_TIMEOUT_EN
    localparam logic [15:0] ACK_LAST = 16'(ACK_TIMEOUT - 1);
`endif

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HALT    = 3'd1,
        ST_FETCH   = 3'd2,
        ST_WRITE   = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    state_t              state_r, next_state_s;
    logic [15:0]         cnt_r;
    logic [11:0]         ptr_r, remaining_r;
    logic [11:0]         chip_s, offset_s;
    logic [NUM_ROMS-1:0] chip_sel_s;
    logic                chip_ok_s, accept_s, ack_s, timeout_s, advance_s, last_s;

    logic                byte_ready_r, cyc_r, halt_r, cpu_reset_r, busy_r, done_r, error_r;
    logic [NUM_ROMS-1:0] stb_r;
    logic [31:0]         addr_r, data_r;

    function automatic logic [NUM_ROMS-1:0] chip_onehot(input logic [11:0] chip);
        logic [NUM_ROMS-1:0] sel;
        sel = {NUM_ROMS{1'b0}};
        for (int i = 0; i < NUM_ROMS; i++) begin
            sel[i] = (chip == 12'(i));
        end
        return sel;
    endfunction

    // Address decode, handshake qualifiers and next-state selection.
    always_comb begin
        chip_s     = 12'(ptr_r >> ADDR_BITS);
        offset_s   = ptr_r & OFFSET_MASK;
        chip_ok_s  = (chip_s < ROM_COUNT);
        chip_sel_s = chip_onehot(chip_s);
        accept_s   = (state_r == ST_FETCH) && byte_valid;
        ack_s      = |wb_ack_i;
`ifdef ROM_LOAD_TIMEOUT_EN
        timeout_s  = (state_r == ST_WRITE) && !ack_s && (cnt_r == ACK_LAST);
`else
        timeout_s  = 1'b0;
`endif
        // A byte aimed past the last chip is retired straight from FETCH.
        advance_s  = (accept_s && !chip_ok_s) ||
                     ((state_r == ST_WRITE) && (ack_s || timeout_s));
        last_s     = (remaining_r == 12'd1);
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) next_state_s = ST_HALT;
                else       next_state_s = ST_IDLE;
            end
            ST_HALT: begin
                if (cnt_r == HALT_LAST) begin
                    if (remaining_r == 12'd0) next_state_s = ST_RELEASE;
                    else                      next_state_s = ST_FETCH;
                end else begin
                    next_state_s = ST_HALT;
                end
            end
            ST_FETCH: begin
                if (accept_s && chip_ok_s) next_state_s = ST_WRITE;
                else if (advance_s)        next_state_s = last_s ? ST_RELEASE : ST_FETCH;
                else                       next_state_s = ST_FETCH;
            end
            ST_WRITE: begin
                if (advance_s) next_state_s = last_s ? ST_RELEASE : ST_FETCH;
                else           next_state_s = ST_WRITE;
            end
            ST_RELEASE: begin
                if (cnt_r == RESET_LAST) next_state_s = ST_IDLE;
                else                     next_state_s = ST_RELEASE;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State register and per-phase cycle counter, cleared on every state change.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 16'd0;
        end else begin
            state_r <= next_state_s;
            if (next_state_s != state_r) cnt_r <= 16'd0;
            else if (cnt_r != CNT_TOP)   cnt_r <= cnt_r + 16'd1;
            else                         cnt_r <= cnt_r;
        end
    end

    // Program pointer, byte count, captured bus word and sticky error.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_r       <= 12'd0;
            remaining_r <= 12'd0;
            addr_r      <= 32'd0;
            data_r      <= 32'd0;
            error_r     <= 1'b0;
        end else begin
            if ((state_r == ST_IDLE) && start) begin
                ptr_r       <= base_addr;
                remaining_r <= len;
            end else if (advance_s) begin
                ptr_r       <= ptr_r + 12'd1;
                remaining_r <= remaining_r - 12'd1;
            end
            if (accept_s && chip_ok_s) begin
                addr_r <= {18'd0, offset_s, 2'b00};
                data_r <= {24'd0, byte_data};
            end
            if ((state_r == ST_IDLE) && start)           error_r <= 1'b0;
            else if ((accept_s && !chip_ok_s) || timeout_s) error_r <= 1'b1;
        end
    end

    // Control outputs are registered from the next state so they line up with it.
    always_ff @(posedge clock) begin
        if (reset) begin
            byte_ready_r <= 1'b0;
            cyc_r        <= 1'b0;
            stb_r        <= {NUM_ROMS{1'b0}};
            halt_r       <= 1'b0;
            cpu_reset_r  <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            byte_ready_r <= (next_state_s == ST_FETCH);
            cyc_r        <= (next_state_s == ST_WRITE);
            stb_r        <= (next_state_s == ST_WRITE) ? chip_sel_s : {NUM_ROMS{1'b0}};
            halt_r       <= (next_state_s != ST_IDLE);
            cpu_reset_r  <= (next_state_s == ST_RELEASE);
            busy_r       <= (next_state_s != ST_IDLE);
            done_r       <= (state_r == ST_RELEASE) && (next_state_s == ST_IDLE);
        end
    end

    assign byte_ready = byte_ready_r;
    assign wb_cyc_o   = cyc_r;
    assign wb_stb_o   = stb_r;
    assign wb_we_o    = cyc_r;
    assign wb_addr_o  = addr_r;
    assign wb_data_o  = data_r;
    assign halt       = halt_r;
    assign cpu_reset  = cpu_reset_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign error      = error_r;
endmodule
